// File: rtl/dmem_access_if.sv
// CPU-side request/response bundle for the data-memory access unit.
// The master drives a request; the slave answers with done/fault/ld_data.
interface dmem_access_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        ready;
    logic        done;
    logic        fault;
    logic [31:0] ld_data;

    modport master (
        output req, op, addr, st_data,
        input  ready, done, fault, ld_data
    );

    modport slave (
        input  req, op, addr, st_data,
        output ready, done, fault, ld_data
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Load/store front end for a 32-bit word memory: sub-word loads with
// extension, read-modify-write byte/halfword stores, fault detection.
module dmem_access_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h10010000,
    parameter int          MEM_WORDS = 2048
) (
    input  logic         clk,
    input  logic         rst_n,
    dmem_access_if.slave cpu,
    output logic [10:0]  dm_addr,
    output logic         dm_cs,
    output logic         dm_r,
    output logic         dm_w,
    output logic [31:0]  dm_wdata,
    input  logic [31:0]  dm_rdata
);
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SB  = 3'd6;
    localparam logic [2:0] OP_SH  = 3'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [31:0] WIN = 32'(MEM_WORDS * 4);

    logic [1:0]  state, nxt;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic [31:0] st_q;
    logic [31:0] merge_q;
    logic [10:0] idx_q;
    logic        fault_q;

    logic [31:0] offset;
    logic        mis;
    logic        acc_fault;
    logic        accept;
    logic        is_rmw;
    logic        is_ld;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] ld_nxt;

    assign offset    = cpu.addr - BASE_ADDR;
    assign acc_fault = mis | (offset >= WIN);
    assign accept    = (state == S_IDLE) & cpu.req;
    assign is_rmw    = (op_q == OP_SB) | (op_q == OP_SH);
    assign is_ld     = (op_q <= OP_LHU);

    always_comb begin
        mis = 1'b0;
        unique case (cpu.op)
            OP_LW, OP_SW:         mis = |cpu.addr[1:0];
            OP_LH, OP_LHU, OP_SH: mis = cpu.addr[0];
            default:              mis = 1'b0;
        endcase
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:
                if (cpu.req) begin
                    if (acc_fault)
                        nxt = S_DONE;
                    else if (cpu.op == OP_SW)
                        nxt = S_WR;
                    else
                        nxt = S_RD;
                end
            S_RD:    nxt = is_rmw ? S_WR : S_DONE;
            S_WR:    nxt = S_DONE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rbyte  = dm_rdata[{lane_q, 3'b000} +: 8];
        rhalf  = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        ld_nxt = dm_rdata;
        unique case (op_q)
            OP_LB:   ld_nxt = {{24{rbyte[7]}}, rbyte};
            OP_LBU:  ld_nxt = {24'd0, rbyte};
            OP_LH:   ld_nxt = {{16{rhalf[15]}}, rhalf};
            OP_LHU:  ld_nxt = {16'd0, rhalf};
            default: ld_nxt = dm_rdata;
        endcase
    end

    // Store word is built only from latched state, never from the live request.
    always_comb begin
        dm_wdata = merge_q;
        unique case (op_q)
            OP_SB: dm_wdata[{lane_q, 3'b000} +: 8] = st_q[7:0];
            OP_SH:
                if (lane_q[1])
                    dm_wdata[31:16] = st_q[15:0];
                else
                    dm_wdata[15:0] = st_q[15:0];
            default: dm_wdata = st_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= 3'd0;
            lane_q      <= 2'd0;
            st_q        <= 32'd0;
            merge_q     <= 32'd0;
            idx_q       <= 11'd0;
            fault_q     <= 1'b0;
            cpu.ld_data <= 32'd0;
        end else begin
            state <= nxt;
            if (accept) begin
                op_q    <= cpu.op;
                lane_q  <= cpu.addr[1:0];
                st_q    <= cpu.st_data;
                idx_q   <= offset[12:2];
                fault_q <= acc_fault;
            end
            if (state == S_RD) begin
                if (is_rmw)
                    merge_q <= dm_rdata;
                else if (is_ld)
                    cpu.ld_data <= ld_nxt;
            end
        end
    end

    assign cpu.ready = (state == S_IDLE);
    assign cpu.done  = (state == S_DONE);
    assign cpu.fault = (state == S_DONE) & fault_q;
    assign dm_cs     = (state == S_RD) | (state == S_WR);
    assign dm_r      = (state == S_RD);
    assign dm_w      = (state == S_WR);
    assign dm_addr   = idx_q;
endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
Load/store front end placed directly upstream of the word-organised data memory (2048 x 32, 11-bit word address, chip select plus read/write enables, combinational read, write on posedge clk). Accepts one CPU memory request at a time with a byte address and a MIPS access type. Performs sub-word loads with sign or zero extension. Performs byte and halfword stores as a read-modify-write sequence on the 32-bit memory. Flags misaligned and out-of-range accesses without touching memory.

Parameters:
BASE_ADDR, 32'h10010000, byte address that maps to memory word 0.
MEM_WORDS, 2048, memory depth in words; the window spans MEM_WORDS*4 bytes.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  1  request strobe; sampled only while ready=1.
op  input  3  access type: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH.
addr  input  32  byte address.
st_data  input  32  store data; SB uses [7:0], SH uses [15:0].
ready  output  1  high in IDLE only.
done  output  1  one-cycle completion pulse.
fault  output  1  valid with done; 1 = misaligned or out of range.
ld_data  output  32  load result, registered.
dm_addr  output  11  memory word address.
dm_cs  output  1  memory chip select.
dm_r  output  1  memory read enable.
dm_w  output  1  memory write enable.
dm_wdata  output  32  word to write; drives the memory data-in port.
dm_rdata  input  32  word read from memory.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ready=1; done=0; fault=0; ld_data=0; latched request registers=0. dm_cs, dm_r and dm_w are decoded from state, so they drop to 0 immediately. A reset mid-sequence never issues a write.
- States: IDLE, RD, WR, DONE.
- Accept: at a posedge with state=IDLE and req=1, latch op, addr and st_data. Compute offset = addr - BASE_ADDR, 32-bit unsigned wrap. Word index = offset[12:2].
- Fault check at accept:
  - misaligned: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0;
  - out of range: offset >= MEM_WORDS*4.
  - On fault, go directly to DONE with fault=1. ld_data is unchanged. No memory access occurs.
- Transitions:
  - loads: IDLE -> RD -> DONE;
  - SW: IDLE -> WR -> DONE;
  - SB/SH: IDLE -> RD -> WR -> DONE;
  - DONE -> IDLE unconditionally.
- RD: dm_cs=1, dm_r=1, dm_w=0, dm_addr=latched index.
  - For loads, ld_data is loaded at the end of RD.
  - For SB/SH, the word is captured into an internal merge register.
- WR: dm_cs=1, dm_w=1, dm_r=0, dm_addr=latched index.
  - SW: dm_wdata = st_data.
  - SB: merge word with byte lane addr[1:0] replaced by st_data[7:0].
  - SH: merge word with halfword lane addr[1] replaced by st_data[15:0].
- Little-endian lanes: byte k = bits [8k+7:8k]; halfword h = bits [16h+15:16h].
- Load extraction: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- In IDLE and DONE: dm_cs=dm_r=dm_w=0; dm_addr and dm_wdata hold their latched values.
- DONE: done=1 for exactly one cycle, ready=0. fault holds the latched fault flag during DONE and is 0 otherwise. ld_data holds until the next successful load completes.
- Latency, accept edge to done high:
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles;
  - fault: 1 cycle.
- req while ready=0 is ignored; there is no queueing. Back-to-back requests can be accepted every (latency+1) cycles, since DONE returns to IDLE.
- No combinational path from req, op or addr to any dm_* output.

Test Plan:
- SW addr=0x10010004, st_data=0xDEADBEEF; then LW same address -> dm_addr=1; one dm_w cycle with dm_wdata=0xDEADBEEF; LW returns ld_data=0xDEADBEEF, done 2 cycles after each accept, fault=0.
- Preload word 1 = 0x8899AABB. Run LB/LBU at 0x10010006 and LH/LHU at 0x10010006 -> LB=0xFFFFFF99, LBU=0x00000099, LH=0xFFFF8899, LHU=0x00008899.
- Word 1 = 0x11223344. SB 0x10010005 with data 0xA5, then SH 0x10010006 with data 0xBEEF -> exactly one RD then one WR each. Final word = 0xBEEFA544. done 3 cycles after accept.
- LW 0x10010002, SH 0x10010001, and LW 0x10012000 (out of range) -> done 1 cycle after accept with fault=1. dm_cs never asserted. ld_data unchanged.
- Hold req=1 continuously with alternating ops -> one accept per sequence. ready low from accept through DONE. No dm_* activity in IDLE/DONE.
- Assert rst_n=0 during RD of an SB -> dm_cs/dm_w drop immediately, the target word is unchanged, and all outputs return to reset values. The next request after rst_n=1 completes normally.
